instr_fetch_unit: RTL and testbench

//   Consumer of the program counter's fetch address. Takes a PC via valid/ready, issues

---
 rtl/instr_fetch_unit.sv | 154 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues imem reads for offered PCs, buffers {pc, instr} for decode, flush kills work.
// Optional perf counters (perf_stall, perf_flush) enabled by defining IF_PERF_CNT_EN.
module instr_fetch_unit #(
  parameter int unsigned PC_W    = 64,
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned DEPTH   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pc_valid,
  input  logic [PC_W-1:0]    pc_in,
  output logic               pc_ready,
  input  logic               flush,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [PC_W-1:0]    if_pc,
  input  logic               if_ready
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]        perf_stall,
  output logic [31:0]        perf_flush
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {RUN, FULL, FLUSH} state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       occ, occ_nxt, os_cnt, os_nxt, drop_cnt, drop_nxt;
  logic [AW-1:0]       tag_wr, tag_wr_nxt, tag_rd, tag_rd_nxt;
  logic [AW-1:0]       buf_wr, buf_wr_nxt, buf_rd, buf_rd_nxt;
  logic                valid_nxt;
  logic [PC_W-1:0]     pc_nxt;
  logic [INSTR_W-1:0]  instr_nxt;
  logic [PC_W-1:0]     tag_mem [DEPTH];
  logic [PC_W-1:0]     pc_mem  [DEPTH];
  logic [INSTR_W-1:0]  ins_mem [DEPTH];
  logic                grant, pop, resp, drop_hit;

  // Request gated by reset so nothing escapes while the block is held in reset.
  assign imem_req  = rst_n & pc_valid & (state == RUN) & ((occ + os_cnt) < CW'(DEPTH)) & ~flush;
  assign imem_addr = pc_in;
  assign pc_ready  = imem_req & imem_gnt;
  assign grant     = pc_ready;
  assign pop       = if_valid & if_ready;
  assign resp      = imem_rvalid & (os_cnt != '0) & (state != FLUSH);
  assign drop_hit  = imem_rvalid & (state == FLUSH) & (drop_cnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    occ_nxt    = occ;
    os_nxt     = os_cnt;
    drop_nxt   = drop_cnt;
    tag_wr_nxt = tag_wr;
    tag_rd_nxt = tag_rd;
    buf_wr_nxt = buf_wr;
    buf_rd_nxt = buf_rd;
    valid_nxt  = if_valid;
    pc_nxt     = if_pc;
    instr_nxt  = if_instr;
    if (flush) begin
      occ_nxt    = '0;
      os_nxt     = '0;
      tag_wr_nxt = '0;
      tag_rd_nxt = '0;
      buf_wr_nxt = '0;
      buf_rd_nxt = '0;
      // A response arriving with the flush is itself one of the killed reads.
      if (state == FLUSH) drop_nxt = drop_cnt - CW'(drop_hit);
      else                drop_nxt = os_cnt - CW'(resp);
      state_nxt = (drop_nxt != '0) ? FLUSH : RUN;
      valid_nxt = 1'b0;
    end else begin
      occ_nxt    = occ + CW'(resp) - CW'(pop);
      os_nxt     = os_cnt + CW'(grant) - CW'(resp);
      drop_nxt   = drop_cnt - CW'(drop_hit);
      tag_wr_nxt = tag_wr + AW'(grant);
      tag_rd_nxt = tag_rd + AW'(resp);
      buf_wr_nxt = buf_wr + AW'(resp);
      buf_rd_nxt = buf_rd + AW'(pop);
      if (state == FLUSH) state_nxt = (drop_nxt == '0) ? RUN : FLUSH;
      else                state_nxt = ((occ_nxt + os_nxt) >= CW'(DEPTH)) ? FULL : RUN;
      valid_nxt = (occ_nxt != '0);
      // Forward the incoming response when it becomes the new head.
      if (resp && (buf_wr == buf_rd_nxt)) begin
        pc_nxt    = tag_mem[tag_rd];
        instr_nxt = imem_rdata;
      end else if (occ_nxt != '0) begin
        pc_nxt    = pc_mem[buf_rd_nxt];
        instr_nxt = ins_mem[buf_rd_nxt];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ      <= '0;
      os_cnt   <= '0;
      drop_cnt <= '0;
      tag_wr   <= '0;
      tag_rd   <= '0;
      buf_wr   <= '0;
      buf_rd   <= '0;
      if_valid <= 1'b0;
      if_pc    <= '0;
      if_instr <= '0;
    end else begin
      occ      <= occ_nxt;
      os_cnt   <= os_nxt;
      drop_cnt <= drop_nxt;
      tag_wr   <= tag_wr_nxt;
      tag_rd   <= tag_rd_nxt;
      buf_wr   <= buf_wr_nxt;
      buf_rd   <= buf_rd_nxt;
      if_valid <= valid_nxt;
      if_pc    <= pc_nxt;
      if_instr <= instr_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (grant) tag_mem[tag_wr] <= pc_in;
    if (resp && !flush) begin
      pc_mem[buf_wr]  <= tag_mem[tag_rd];
      ins_mem[buf_wr] <= imem_rdata;
    end
  end

`ifdef IF_PERF_CNT_EN
  // Saturating event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall <= '0;
      perf_flush <= '0;
    end else begin
      if (pc_valid && !pc_ready && (perf_stall != 32'hFFFF_FFFF)) perf_stall <= perf_stall + 32'd1;
      if (flush && (perf_flush != 32'hFFFF_FFFF)) perf_flush <= perf_flush + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit (DEPTH=2); perf counters checked when IF_PERF_CNT_EN is defined.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_valid;
  logic [63:0] pc_in;
  logic        pc_ready;
  logic        flush;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [63:0] if_pc;
  logic        if_ready;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_stall;
  logic [31:0] perf_flush;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.PC_W(64), .INSTR_W(32), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .pc_valid(pc_valid), .pc_in(pc_in), .pc_ready(pc_ready),
    .flush(flush), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .if_valid(if_valid),
    .if_instr(if_instr), .if_pc(if_pc), .if_ready(if_ready)
`ifdef IF_PERF_CNT_EN
    , .perf_stall(perf_stall), .perf_flush(perf_flush)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic pv, input logic [63:0] pc, input logic gnt, input logic rv,
                       input logic [31:0] rd, input logic rdy, input logic fl);
    pc_valid = pv; pc_in = pc; imem_gnt = gnt; imem_rvalid = rv;
    imem_rdata = rd; if_ready = rdy; flush = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("rst_valid", 64'(if_valid), 64'd0);
    chk("rst_pc", if_pc, 64'd0);
    chk("rst_instr", 64'(if_instr), 64'd0);
    chk("rst_req", 64'(imem_req), 64'd0);
    tick();
    rst_n = 1'b1;

    // Streaming
    drive(1, 64'd0, 1, 0, 0, 1, 0);
    chk("s1_req", 64'(imem_req), 64'd1);
    chk("s1_addr", imem_addr, 64'd0);
    tick();
    drive(1, 64'd1, 1, 1, 32'hA0, 1, 0);
    chk("s2_ready", 64'(pc_ready), 64'd1);
    chk("s2_valid", 64'(if_valid), 64'd0);
    tick();
    drive(1, 64'd2, 1, 1, 32'hA1, 1, 0);
    chk("s3_req_full", 64'(imem_req), 64'd0);
    chk("s3_valid", 64'(if_valid), 64'd1);
    chk("s3_pc", if_pc, 64'd0);
    chk("s3_instr", 64'(if_instr), 64'hA0);
    tick();
    drive(1, 64'd2, 1, 0, 0, 1, 0);
    chk("s4_req", 64'(imem_req), 64'd1);
    chk("s4_pc", if_pc, 64'd1);
    chk("s4_instr", 64'(if_instr), 64'hA1);
    tick();
    drive(0, 0, 0, 1, 32'hA2, 1, 0);
    chk("s5_valid", 64'(if_valid), 64'd0);
    tick();
    drive(0, 0, 0, 0, 0, 1, 0);
    chk("s6_pc", if_pc, 64'd2);
    chk("s6_instr", 64'(if_instr), 64'hA2);
    tick();
    chk("s7_valid", 64'(if_valid), 64'd0);

    // Back-pressure
    drive(1, 64'h10, 1, 0, 0, 0, 0);
    chk("b1_req", 64'(imem_req), 64'd1);
    tick();
    drive(1, 64'h11, 1, 1, 32'hB0, 0, 0);
    chk("b2_req", 64'(imem_req), 64'd1);
    tick();
    drive(1, 64'h12, 1, 1, 32'hB1, 0, 0);
    chk("b3_req", 64'(imem_req), 64'd0);
    tick();
    drive(1, 64'h12, 1, 0, 0, 0, 0);
    chk("b4_req", 64'(imem_req), 64'd0);
    chk("b4_pc_hold", if_pc, 64'h10);
    chk("b4_instr_hold", 64'(if_instr), 64'hB0);
    tick();
    drive(1, 64'h12, 1, 0, 0, 1, 0);
    chk("b5_req", 64'(imem_req), 64'd0);
    chk("b5_pc", if_pc, 64'h10);
    tick();
    drive(1, 64'h12, 1, 0, 0, 1, 0);
    chk("b6_req", 64'(imem_req), 64'd1);
    chk("b6_pc", if_pc, 64'h11);
    chk("b6_instr", 64'(if_instr), 64'hB1);
    tick();
    drive(0, 0, 0, 1, 32'hB2, 1, 0);
    chk("b7_valid", 64'(if_valid), 64'd0);
    tick();
    drive(0, 0, 0, 0, 0, 1, 0);
    chk("b8_pc", if_pc, 64'h12);
    chk("b8_instr", 64'(if_instr), 64'hB2);
    tick();

    // Flush with two reads outstanding
    drive(1, 64'h20, 1, 0, 0, 1, 0);
    tick();
    drive(1, 64'h21, 1, 0, 0, 1, 0);
    chk("f2_req", 64'(imem_req), 64'd1);
    tick();
    drive(1, 64'h22, 1, 0, 0, 1, 1);
    chk("f3_req", 64'(imem_req), 64'd0);
    tick();
    drive(1, 64'h40, 1, 1, 32'hDEAD, 1, 0);
    chk("f4_req", 64'(imem_req), 64'd0);
    chk("f4_valid", 64'(if_valid), 64'd0);
    tick();
    drive(1, 64'h40, 1, 1, 32'hBEEF, 1, 0);
    chk("f5_req", 64'(imem_req), 64'd0);
    chk("f5_valid", 64'(if_valid), 64'd0);
    tick();
    drive(1, 64'h40, 1, 0, 0, 1, 0);
    chk("f6_req", 64'(imem_req), 64'd1);
    chk("f6_addr", imem_addr, 64'h40);
    chk("f6_valid", 64'(if_valid), 64'd0);
    tick();
    drive(0, 0, 0, 1, 32'h4444, 1, 0);
    chk("f7_valid", 64'(if_valid), 64'd0);
    tick();
    drive(0, 0, 0, 0, 0, 1, 0);
    chk("f8_valid", 64'(if_valid), 64'd1);
    chk("f8_pc", if_pc, 64'h40);
    chk("f8_instr", 64'(if_instr), 64'h4444);
    tick();

    // Flush together with the only outstanding response
    drive(1, 64'h50, 1, 0, 0, 1, 0);
    tick();
    drive(0, 0, 0, 1, 32'h55, 1, 1);
    tick();
    drive(1, 64'h60, 0, 0, 0, 1, 0);
    chk("g3_req_run", 64'(imem_req), 64'd1);
    chk("g3_valid", 64'(if_valid), 64'd0);
    tick();
    drive(0, 0, 0, 1, 32'h66, 1, 0);
    chk("g4_valid", 64'(if_valid), 64'd0);
    tick();
    drive(0, 0, 0, 0, 0, 1, 0);
    chk("g5_stray_ignored", 64'(if_valid), 64'd0);

    // Async reset mid-stream
    drive(1, 64'h70, 1, 0, 0, 0, 0);
    tick();
    drive(1, 64'h71, 1, 1, 32'h77, 0, 0);
    tick();
    chk("r3_valid", 64'(if_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("r3_rst_valid", 64'(if_valid), 64'd0);
    chk("r3_rst_pc", if_pc, 64'd0);
    chk("r3_rst_instr", 64'(if_instr), 64'd0);
    chk("r3_rst_req", 64'(imem_req), 64'd0);
    chk("r3_rst_ready", 64'(pc_ready), 64'd0);
    tick();
    rst_n = 1'b1;
    drive(0, 0, 0, 1, 32'h99, 1, 0);
    tick();
    drive(1, 64'h80, 1, 0, 0, 1, 0);
    chk("r4_stray_valid", 64'(if_valid), 64'd0);
    chk("r4_req", 64'(imem_req), 64'd1);
    tick();
    drive(0, 0, 0, 1, 32'h88, 1, 0);
    tick();
    drive(0, 0, 0, 0, 0, 1, 0);
    chk("r5_pc", if_pc, 64'h80);
    chk("r5_instr", 64'(if_instr), 64'h88);
    tick();

`ifdef IF_PERF_CNT_EN
    rst_n = 1'b0;
    #1;
    chk("p_rst_stall", 64'(perf_stall), 64'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1, 64'h90, 0, 0, 0, 1, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 1, 1);
    tick();
    drive(0, 0, 0, 0, 0, 1, 0);
    tick();
    drive(0, 0, 0, 0, 0, 1, 1);
    tick();
    drive(0, 0, 0, 0, 0, 1, 0);
    chk("p_stall", 64'(perf_stall), 64'd5);
    chk("p_flush", 64'(perf_flush), 64'd2);
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
